// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: derives I2S SCK and WS from clk_in, plus clk_in-domain strobes for SCK edges and frame starts.
// Latency: all outputs registered; strobes coincide with the output edge they mark. Start/stop only on frame boundaries.
// Backpressure: none; enable_in is a level request, sampled every cycle.
//
// Ports:
//   clk_in           system clock (only clock in the block)
//   rst_n_in         synchronous active-low reset
//   enable_in        run request; stop takes effect at the next frame boundary
//   i2s_clk_out      SCK
//   lrcl_clk_out     WS (0 = left half-frame, 1 = right half-frame)
//   sck_rise_out     one-cycle strobe in the first cycle SCK reads 1
//   sck_fall_out     one-cycle strobe in the first cycle SCK reads 0 after being 1
//   frame_start_out  one-cycle strobe at each frame start
//   running_out      high while clocks are being generated
module i2s_clock_gen #(
    parameter int SCK_HALF_DIV   = 16,
    parameter int BITS_PER_FRAME = 64
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic enable_in,
    output logic i2s_clk_out,
    output logic lrcl_clk_out,
    output logic sck_rise_out,
    output logic sck_fall_out,
    output logic frame_start_out,
    output logic running_out
);

    localparam int HW = (SCK_HALF_DIV > 1) ? $clog2(SCK_HALF_DIV) : 1;
    localparam int BW = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_FRAME - 1);
    localparam logic [BW-1:0] BIT_HALF  = BW'(BITS_PER_FRAME / 2);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_cnt_q, half_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            sck_q, sck_d;
    logic            ws_q, ws_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            fs_q, fs_d;
    logic            running_q, running_d;

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sck_d      = sck_q;
        ws_d       = ws_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        fs_d       = 1'b0;
        running_d  = running_q;

        case (state_q)
            ST_IDLE: begin
                half_cnt_d = '0;
                bit_cnt_d  = '0;
                sck_d      = 1'b0;
                ws_d       = 1'b0;
                running_d  = 1'b0;
                if (enable_in) begin
                    // Entry cycle is itself a frame start.
                    state_d   = ST_RUN;
                    fs_d      = 1'b1;
                    running_d = 1'b1;
                end
            end

            ST_RUN, ST_STOPPING: begin
                running_d = 1'b1;
                // Between boundaries RUN and STOPPING behave identically;
                // the state only records the pending request.
                state_d   = enable_in ? ST_RUN : ST_STOPPING;

                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    sck_d      = ~sck_q;
                    if (!sck_q) begin
                        rise_d = 1'b1;
                    end else begin
                        fall_d = 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            // Frame boundary: the only place start/stop decisions land.
                            // Sampling enable_in here lets a late re-enable continue
                            // seamlessly and a stop request (from either state) end cleanly.
                            bit_cnt_d = '0;
                            ws_d      = 1'b0;
                            if (enable_in) begin
                                state_d = ST_RUN;
                                fs_d    = 1'b1;
                            end else begin
                                state_d   = ST_IDLE;
                                running_d = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                            // WS follows the bit count it is entering, so it only
                            // changes together with an SCK fall.
                            ws_d      = (bit_cnt_d >= BIT_HALF);
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HW'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                running_d = 1'b0;
                sck_d     = 1'b0;
                ws_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            fs_q       <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            fs_q       <= fs_d;
            running_q  <= running_d;
        end
    end

    assign i2s_clk_out     = sck_q;
    assign lrcl_clk_out    = ws_q;
    assign sck_rise_out    = rise_q;
    assign sck_fall_out    = fall_q;
    assign frame_start_out = fs_q;
    assign running_out     = running_q;

endmodule

// File: doc/i2s_clock_gen.md
# i2s_clock_gen

Master clock generator for the I2S microphone front end. It derives the I2S bit clock (SCK) and word-select/LR clock (WS) from the system clock and drives the `i2s_clk` and `lrcl_clk` inputs of the I2S receiver and the microphone. It also provides single-cycle system-domain strobes for SCK edges and frame starts, so system-clock logic can align to the audio frame. Start and stop are glitch-free and occur only on frame boundaries.

## Interface
- SCK_HALF_DIV, 16: `clk_in` cycles per SCK half-period; ≥1. Default gives 3.072 MHz SCK from 98.304 MHz.
- BITS_PER_FRAME, 64: SCK cycles per WS period; even, ≥2. Default gives 48 kHz frames.
- clk_in  input  1  system clock; the only clock in the block.
- rst_n_in  input  1  reset; synchronous, active-low.
- enable_in  input  1  request to run clocks; level-sensitive.
- i2s_clk_out  output  1  SCK, registered.
- lrcl_clk_out  output  1  WS, registered; 0 = left half-frame, 1 = right half-frame.
- sck_rise_out  output  1  one-cycle strobe; high in the cycle `i2s_clk_out` first reads 1.
- sck_fall_out  output  1  one-cycle strobe; high in the cycle `i2s_clk_out` first reads 0 after being 1.
- frame_start_out  output  1  one-cycle strobe at each frame start (WS low, bit count 0).
- running_out  output  1  high while in RUN or STOPPING.

## Operation
- States:
  - IDLE: SCK=0, WS=0, counters 0.
  - RUN: clocks toggle normally.
  - STOPPING: clocks keep toggling until the end of the current frame.
- Reset (`rst_n_in`=0 at a `clk_in` edge): state goes to IDLE and every output is 0 the next cycle, regardless of `enable_in` or current state. This includes reset in mid-frame.
- IDLE→RUN when `enable_in`=1. The entry cycle loads half_cnt=0, bit_cnt=0, SCK=0, WS=0, and asserts frame_start_out and running_out.
- half_cnt (width max(1, clog2(SCK_HALF_DIV))), updated each cycle in RUN and STOPPING:
  - If half_cnt==SCK_HALF_DIV-1, set half_cnt←0 and toggle SCK.
  - Otherwise increment half_cnt.
- bit_cnt (0..BITS_PER_FRAME-1) advances on each SCK 1→0 toggle and wraps to 0.
- WS is registered: WS = (next bit_cnt ≥ BITS_PER_FRAME/2). WS therefore changes only together with an SCK falling edge, per the I2S standard.
- frame_start_out pulses on the falling toggle where bit_cnt wraps to 0, provided the state stays RUN. It also pulses on IDLE→RUN entry.
- RUN→STOPPING when `enable_in`=0.
- STOPPING→RUN when `enable_in`=1. Output is uninterrupted and the next frame_start_out occurs at the normal time.
- STOPPING→IDLE on the falling toggle where bit_cnt wraps to 0:
  - SCK=0 and WS=0 that cycle; sck_fall_out pulses.
  - frame_start_out does not pulse; running_out drops that same cycle.
- SCK high and low phases are always exactly SCK_HALF_DIV cycles; there are no runt pulses.

## Timing
- Define cycle 1 as the first cycle with running_out=1 (enable sampled high at the edge ending cycle 0). Let H=SCK_HALF_DIV and B=BITS_PER_FRAME.
- First SCK rise is visible at cycle 1+H; first fall at 1+2H. SCK period is 2H cycles.
- WS rises at cycle 1+2H·(B/2) and falls at 1+2H·B.
- frame_start_out pulses at cycles 1, 1+2HB, 1+4HB, …
- Each strobe is exactly one cycle and aligned with the registered output change; latency is 0 relative to the output edge.
- Exactly B sck_rise_out and B sck_fall_out pulses occur per frame.

## Test plan
- Reset: hold `rst_n_in`=0 with `enable_in`=1 for 50 cycles -> all outputs 0 throughout.
- Start with defaults (H=16, B=64), `enable_in`=1 at cycle 0:
  - running_out and frame_start_out at cycle 1; SCK rise at 17, fall at 33.
  - WS rise at 1025; frame_start_out at 2049 and 4097.
  - 64 rise strobes per frame.
- Stop mid-frame: deassert `enable_in` at cycle 500 -> clocks continue unchanged; at cycle 2049 SCK falls, WS falls and running_out=0, with no frame_start_out; outputs stay 0 for the following 500 cycles.
- Re-enable in STOPPING: deassert at 500, reassert at 1800 -> no gap; frame_start_out at 2049; running_out stays 1.
- Reset mid-operation: `rst_n_in`=0 for one cycle at cycle 1500 with enable high -> all outputs 0 the next cycle; after release, timing restarts exactly as in the Start scenario, relative to the new cycle 1.
- Small parameters (H=1, B=4): SCK toggles every cycle; WS period 8 cycles; WS high for 4; frame_start_out every 8 cycles; strobes never overlap incorrectly.
